ysyx_23060077_pipe_stage_hs: RTL
================================

// Module: ysyx_23060077_pipe_stage_hs
// PURPOSE
//  Parametrised valid/ready pipeline stage between core stages (IF/ID/EX/LS/WB).
//  Back-pressure comes from out_ready, flush from the branch/exception unit.
//  Optional skid entry gives full throughput with a registered in_ready.
//  Idle or flushed payload reads back as RESET_VAL.
// PARAMETERS
//  WIDTH      32  payload width in bits
//  RESET_VAL  0   payload value after reset or flush, and whenever the stage is empty
// PORTS
//  clock      in   1      sole clock, rising edge
//  reset      in   1      asynchronous, active-low; stage is cleared while reset==0
//  flush      in   1      synchronous kill of all held and incoming beats
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      stage can accept; transfer = in_valid & in_ready
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      stage holds a beat for downstream
//  out_ready  in   1      downstream accepts; transfer = out_valid & out_ready
//  out_data   out  WIDTH  payload of the head entry
//  count      out  2      occupied entries (0..2; max 1 without skid)
// BEHAVIOUR
//  - Reset (reset==0, async): out_valid=0, out_data=RESET_VAL, count=0, skid empty.
//    First clock edge after release: in_ready=1.
//  - in_ready is gated by ~flush combinationally. No input transfer occurs in a flush cycle.
//  - Flush (sync, highest priority after reset): next edge gives out_valid=0,
//    out_data=RESET_VAL, count=0, skid cleared. Any output handshake in the same cycle still completes.
//  - Latency is one cycle from in transfer to out_valid. Peak throughput is one beat per cycle.
//  - out_valid/out_data stay stable while out_valid & ~out_ready. They change only on
//    out transfer, flush or reset.
//  - Head register: loads in_data on in transfer when empty or draining that cycle.
//    Loads RESET_VAL when drained with no replacement.
//  - Simultaneous in and out transfer: head replaced, count unchanged.
//  - count = out_valid + skid_valid. It never reaches 3. No overflow is possible because in_ready gates input.
// CONFIGURATION
//  YSYX_23060077_PIPE_SKID_EN defined:
//   - two entries (head + skid); in_ready = ~skid_valid, taken straight from a flop (then & ~flush).
//   - head full & ~out_ready & in transfer: beat goes to skid, count=2,
//     in_ready=0 from the next cycle.
//   - out transfer with skid full: head<=skid, skid<=empty/RESET_VAL, in_ready=1 next cycle.
//     The input stays closed this cycle.
//   - Beat order is strictly preserved (head before skid).
//  YSYX_23060077_PIPE_SKID_EN undefined:
//   - single entry; in_ready = (~out_valid | out_ready) & ~flush, combinational from out_ready.
//   - count is 0 or 1 only. The skid logic is absent.
// TESTING
//  1. Reset: hold reset=0 with in_valid=1 and in_data=32'hDEAD -> out_valid=0, out_data=0, count=0.
//     One edge after release, in_ready=1.
//  2. Stream: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles,
//     one cycle late, no bubbles.
//  3. Stall: send 0xA,0xB with out_ready=0.
//     - skid: count=2, in_ready=0.
//     - no skid: 0xB waits, in_ready=0.
//     Then raise out_ready -> 0xA, then 0xB, order kept; count returns to 0.
//  4. Flush while full (count=2), in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=0,
//     count=0, 0xC not delivered.
//  5. Simultaneous in/out each cycle with out_ready toggling 1,0,1,0 -> no beat lost or duplicated.
//     Scoreboard matches; out_data stable while stalled.
//  6. Assert reset=0 mid-stream with count=2 -> outputs clear immediately without a clock edge.
//     After release, the stage resumes from empty.

Source files
------------

// File: rtl/ysyx_23060077_pipe_stage_hs.sv
// Valid/ready pipeline stage between core stages with flush and optional skid entry.
// Ports: clock, reset (async, active-low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count (occupied entries 0..2).
// Optional feature macro: YSYX_23060077_PIPE_SKID_EN (second entry, registered in_ready).
module ysyx_23060077_pipe_stage_hs #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             head_v, head_v_n;
    logic [WIDTH-1:0] head_d, head_d_n;
    logic             in_fire, out_fire;

    assign out_valid = head_v;
    assign out_data  = head_d;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = head_v & out_ready;

`ifdef YSYX_23060077_PIPE_SKID_EN

    logic             skid_v, skid_v_n;
    logic [WIDTH-1:0] skid_d, skid_d_n;

    // Acceptance depends only on the skid flop, never on out_ready.
    assign in_ready = ~skid_v & ~flush;
    assign count    = {1'b0, head_v} + {1'b0, skid_v};

    always_comb begin
        head_v_n = head_v;
        head_d_n = head_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (flush) begin
            head_v_n = 1'b0;
            head_d_n = RESET_VAL;
            skid_v_n = 1'b0;
            skid_d_n = RESET_VAL;
        end else begin
            unique case (1'b1)
                out_fire & skid_v: begin
                    // Skid promotes to head; input is closed this cycle.
                    head_v_n = 1'b1;
                    head_d_n = skid_d;
                    skid_v_n = 1'b0;
                    skid_d_n = RESET_VAL;
                end
                out_fire & ~skid_v: begin
                    head_v_n = in_fire;
                    head_d_n = in_fire ? in_data : RESET_VAL;
                end
                ~out_fire & in_fire & head_v: begin
                    skid_v_n = 1'b1;
                    skid_d_n = in_data;
                end
                ~out_fire & in_fire & ~head_v: begin
                    head_v_n = 1'b1;
                    head_d_n = in_data;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_v <= 1'b0;
            head_d <= RESET_VAL;
            skid_v <= 1'b0;
            skid_d <= RESET_VAL;
        end else begin
            head_v <= head_v_n;
            head_d <= head_d_n;
            skid_v <= skid_v_n;
            skid_d <= skid_d_n;
        end
    end

`else

    // Single entry: a draining head may be refilled in the same cycle.
    assign in_ready = (~head_v | out_ready) & ~flush;
    assign count    = {1'b0, head_v};

    always_comb begin
        head_v_n = head_v;
        head_d_n = head_d;
        unique case (1'b1)
            flush: begin
                head_v_n = 1'b0;
                head_d_n = RESET_VAL;
            end
            ~flush & in_fire: begin
                head_v_n = 1'b1;
                head_d_n = in_data;
            end
            ~flush & ~in_fire & out_fire: begin
                head_v_n = 1'b0;
                head_d_n = RESET_VAL;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_v <= 1'b0;
            head_d <= RESET_VAL;
        end else begin
            head_v <= head_v_n;
            head_d <= head_d_n;
        end
    end

`endif

endmodule
